// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: drives one external full-adder cell LSB-first for WIDTH cycles,
// shifts the sum bits into a result register and returns the final carry.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  s_sh_q, s_sh_d;
  logic              c_q, c_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              busy_q, done_q;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_sh_d  = a_in;
          b_sh_d  = b_in;
          c_d     = cin;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
        c_d    = fa_co;
        if (cnt_q == CntLast) begin
          // Result only becomes visible on the last bit, never mid-operation.
          sum_d   = {fa_s, s_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  // Cell inputs come straight from registers so the FA path stays single-cycle.
  assign fa_a  = (state_q == StRun) & a_sh_q[0];
  assign fa_b  = (state_q == StRun) & b_sh_q[0];
  assign fa_ci = (state_q == StRun) & c_q;

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomized bench for serial_adder_ctrl with a behavioural full-adder cell
// and an arithmetic reference model (a + b + cin).
module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
  logic         fa_a, fa_b, fa_ci, fa_s, fa_co;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [W-1:0] ref_sum  = '0;
  logic         ref_cout = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; check the always-true rules.
  task automatic tick();
    @(posedge clk);
    #1;
    check("done_with_busy", 32'(done & busy), 32'd0);
    if (!busy) check("fa_outside_run", 32'({fa_a, fa_b, fa_ci}), 32'd0);
  endtask

  // One full operation; glitch >= 1 re-pulses start with new operands during that RUN cycle.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input int glitch);
    int e;
    e = int'(a) + int'(b) + int'(c);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("done_after_start", 32'(done), 32'd0);
    for (int i = 1; i < W; i++) begin
      a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom);
      if (i == glitch) begin
        start = 1'b1; a_in = 8'h01; b_in = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      check("busy_run", 32'(busy), 32'd1);
      check("sum_held", 32'(sum), 32'(ref_sum));
      check("cout_held", 32'(cout), 32'(ref_cout));
    end
    start = 1'b0;
    tick();
    ref_sum  = e[W-1:0];
    ref_cout = e[W];
    check("done_pulse", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("sum", 32'(sum), 32'(ref_sum));
    check("cout", 32'(cout), 32'(ref_cout));
    tick();
    check("done_single", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_ci}), 32'd0);
    rst = 1'b0;
    tick();

    do_op(8'h5A, 8'h3C, 1'b0, -1);
    check("t1_sum", 32'(sum), 32'h96);
    do_op(8'hFF, 8'h01, 1'b0, -1);
    check("t2a_cout", 32'(cout), 32'd1);
    do_op(8'hFF, 8'hFF, 1'b1, -1);
    check("t2b_sum", 32'(sum), 32'hFF);
    do_op(8'h12, 8'h34, 1'b1, 3);
    tick();
    check("t3_not_queued", 32'(busy), 32'd0);

    // Reset during RUN, with start also high on the reset edge.
    a_in = 8'hC3; b_in = 8'h77; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    ref_sum = '0; ref_cout = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    for (int i = 0; i < W + 2; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end

    // Start held high: back-to-back operations every W+2 cycles.
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    tick();
    check("hold_busy0", 32'(busy), 32'd1);
    a_in = 8'h80; b_in = 8'h80;
    repeat (W - 1) tick();
    tick();
    check("hold_done1", 32'(done), 32'd1);
    check("hold_sum1", 32'(sum), 32'h30);
    check("hold_cout1", 32'(cout), 32'd0);
    tick();
    check("hold_gap_busy", 32'(busy), 32'd0);
    check("hold_gap_done", 32'(done), 32'd0);
    tick();
    check("hold_restart", 32'(busy), 32'd1);
    start = 1'b0;
    repeat (W - 1) tick();
    tick();
    check("hold_done2", 32'(done), 32'd1);
    check("hold_sum2", 32'(sum), 32'h00);
    check("hold_cout2", 32'(cout), 32'd1);
    ref_sum = 8'h00; ref_cout = 1'b1;
    tick();
    check("hold_done2_single", 32'(done), 32'd0);

    for (int n = 0; n < 200; n++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
